// File: rtl/rgb_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rgb_mem_arbiter_pkg
//   Shared types and defaults for the RGB pixel memory arbiter.
//   - rgb_channel_t : channel plane code, same encoding as the decoder RGB field
//   - arb_state_t   : arbiter FSM states
//   - nextGrant()   : grant decision taken at every FSM decision point
// ---------------------------------------------------------------------------
package rgb_mem_arbiter_pkg;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_MAX_VGA_STREAK = 4;

    typedef enum logic [1:0] {
        CH_NONE = 2'b00,
        CH_R    = 2'b01,
        CH_G    = 2'b10,
        CH_B    = 2'b11
    } rgb_channel_t;

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_WAIT,
        VGA_R,
        VGA_G,
        VGA_B,
        VGA_DONE
    } arb_state_t;

    // VGA is preferred so the display never tears, unless it has already
    // taken its full streak while the CPU waited; then the CPU goes once.
    function automatic arb_state_t nextGrant(input logic vgaReq,
                                             input logic cpuPending,
                                             input logic streakFull);
        arb_state_t nxt;
        nxt = IDLE;
        if (vgaReq && (!streakFull || !cpuPending)) begin
            nxt = VGA_R;
        end else if (cpuPending) begin
            nxt = CPU_ACC;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rgb_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// rgb_mem_arbiter_if
//   Bundles the three buses around the arbiter.
//   CPU side : cpu_req/we/rgb/addr/wdata in, cpu_rdata/ready/stall out
//   VGA side : vga_req/addr in, vga_ack/pixel/valid out
//   Memory   : mem_en/we/sel/addr/wdata out, mem_rdata in (1-cycle latency)
//   Modports : slave  = the arbiter's view
//              master = the surrounding system (CPU, VGA fetcher, RAM)
// ---------------------------------------------------------------------------
interface rgb_mem_arbiter_if
    import rgb_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic                  cpu_req;
    logic                  cpu_we;
    logic [1:0]            cpu_rgb;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_ready;
    logic                  stall;

    logic                  vga_req;
    logic [ADDR_W-1:0]     vga_addr;
    logic                  vga_ack;
    logic [3*DATA_W-1:0]   vga_pixel;
    logic                  vga_valid;

    logic                  mem_en;
    logic                  mem_we;
    logic [1:0]            mem_sel;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_rgb, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, stall,
        input  vga_req, vga_addr,
        output vga_ack, vga_pixel, vga_valid,
        output mem_en, mem_we, mem_sel, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_rgb, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, stall,
        output vga_req, vga_addr,
        input  vga_ack, vga_pixel, vga_valid,
        input  mem_en, mem_we, mem_sel, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/rgb_mem_arbiter_assembler.sv
// ---------------------------------------------------------------------------
// rgb_pixel_assembler
//   Collects the three channel reads of one VGA fetch and presents the
//   finished pixel.
//   clk, rst     : clock, asynchronous active-high reset
//   capR_i       : mem_rdata holds the red byte this cycle
//   capG_i       : mem_rdata holds the green byte this cycle
//   capB_i       : mem_rdata holds the blue byte this cycle (fetch complete)
//   memRdata_i   : memory read data
//   vgaPixel_o   : {R,G,B}, held until the next fetch completes
//   vgaValid_o   : one-cycle pulse when vgaPixel_o has just been updated
// ---------------------------------------------------------------------------
module rgb_pixel_assembler
    import rgb_mem_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capR_i,
    input  logic                capG_i,
    input  logic                capB_i,
    input  logic [DATA_W-1:0]   memRdata_i,
    output logic [3*DATA_W-1:0] vgaPixel_o,
    output logic                vgaValid_o
);

    logic [DATA_W-1:0]   red_q;
    logic [DATA_W-1:0]   green_q;
    logic [3*DATA_W-1:0] pixel_q;
    logic                valid_q;

    // Red and green are parked until blue arrives; blue is taken straight
    // from the memory bus so the whole pixel updates in a single edge and
    // the display never sees a half-written colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q   <= '0;
            green_q <= '0;
            pixel_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= capB_i;
            if (capR_i) begin
                red_q <= memRdata_i;
            end
            if (capG_i) begin
                green_q <= memRdata_i;
            end
            if (capB_i) begin
                pixel_q <= {red_q, green_q, memRdata_i};
            end
        end
    end

    assign vgaPixel_o = pixel_q;
    assign vgaValid_o = valid_q;

endmodule

// File: rtl/rgb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rgb_mem_arbiter
//   Shares the single-port RGB pixel memory between the CPU memory stage
//   and the VGA scan-out fetcher. A VGA fetch reads R, G and B in three
//   back-to-back cycles; the CPU is stalled while the memory is busy, and
//   a streak counter bounds how long VGA can keep the CPU waiting.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rgb_mem_arbiter_if.slave (CPU, VGA and memory buses)
// ---------------------------------------------------------------------------
module rgb_mem_arbiter
    import rgb_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MAX_VGA_STREAK = DEF_MAX_VGA_STREAK
) (
    input  logic             clk,
    input  logic             rst,
    rgb_mem_arbiter_if.slave bus
);

    localparam int                  STREAK_W   = $clog2(MAX_VGA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VGA_STREAK);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [STREAK_W-1:0]   streak_q;
    logic [STREAK_W-1:0]   streak_d;
    logic [ADDR_W-1:0]     vgaAddr_q;

    logic                  decide;
    logic                  cpuPending;
    logic                  cpuReady;
    logic [DATA_W-1:0]     cpuRdata;
    logic                  vgaAck;
    logic                  memEn;
    logic                  memWe;
    logic [1:0]            memSel;
    logic [ADDR_W-1:0]     memAddr;
    logic [DATA_W-1:0]     memWdata;
    logic [3*DATA_W-1:0]   vgaPixel;
    logic                  vgaValid;

    // State, streak and the latched VGA address. The VGA address is
    // captured in VGA_R so the requester may change it right after the ack;
    // G and B are then read from the same pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            vgaAddr_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            if (state_q == VGA_R) begin
                vgaAddr_q <= bus.vga_addr;
            end
        end
    end

    // Next state and memory/handshake outputs. A request that is being
    // completed this cycle (cpuReady high) is not pending any more, which
    // keeps a finishing store from being granted a second time and lets
    // the streak clear as soon as the CPU is served.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        decide   = 1'b0;
        cpuReady = 1'b0;
        cpuRdata = '0;
        vgaAck   = 1'b0;
        memEn    = 1'b0;
        memWe    = 1'b0;
        memSel   = CH_NONE;
        memAddr  = '0;
        memWdata = '0;

        case (state_q)
            IDLE: begin
                decide = 1'b1;
            end
            CPU_ACC: begin
                memEn    = (bus.cpu_rgb != CH_NONE);
                memWe    = bus.cpu_we;
                memSel   = bus.cpu_rgb;
                memAddr  = bus.cpu_addr;
                memWdata = bus.cpu_wdata;
                if (bus.cpu_we || (bus.cpu_rgb == CH_NONE)) begin
                    cpuReady = 1'b1;
                    decide   = 1'b1;
                end else begin
                    state_d = CPU_WAIT;
                end
            end
            CPU_WAIT: begin
                cpuRdata = bus.mem_rdata;
                cpuReady = 1'b1;
                decide   = 1'b1;
            end
            VGA_R: begin
                vgaAck  = 1'b1;
                memEn   = 1'b1;
                memSel  = CH_R;
                memAddr = bus.vga_addr;
                state_d = VGA_G;
            end
            VGA_G: begin
                memEn   = 1'b1;
                memSel  = CH_G;
                memAddr = vgaAddr_q;
                state_d = VGA_B;
            end
            VGA_B: begin
                memEn   = 1'b1;
                memSel  = CH_B;
                memAddr = vgaAddr_q;
                state_d = VGA_DONE;
            end
            VGA_DONE: begin
                decide = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpuPending = bus.cpu_req & ~cpuReady;

        if (decide) begin
            state_d = nextGrant(bus.vga_req, cpuPending, streak_q >= STREAK_MAX);
        end

        if (!cpuPending || (decide && (state_d == CPU_ACC))) begin
            streak_d = '0;
        end else if (decide && (state_d == VGA_R) && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Data for R arrives during VGA_G, G during VGA_B and B during VGA_DONE.
    rgb_pixel_assembler #(
        .DATA_W (DATA_W)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .capR_i     (state_q == VGA_G),
        .capG_i     (state_q == VGA_B),
        .capB_i     (state_q == VGA_DONE),
        .memRdata_i (bus.mem_rdata),
        .vgaPixel_o (vgaPixel),
        .vgaValid_o (vgaValid)
    );

    assign bus.cpu_rdata = cpuRdata;
    assign bus.cpu_ready = cpuReady;
    assign bus.stall     = bus.cpu_req & ~cpuReady;
    assign bus.vga_ack   = vgaAck;
    assign bus.vga_pixel = vgaPixel;
    assign bus.vga_valid = vgaValid;
    assign bus.mem_en    = memEn;
    assign bus.mem_we    = memWe;
    assign bus.mem_sel   = memSel;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;

endmodule

// File: tb/tb_rgb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rgb_mem_arbiter
//   Testbench for rgb_mem_arbiter: a table of CPU transactions, VGA pixel
//   fetches, CPU starvation under a held VGA request and a reset that
//   aborts a fetch. A behavioural pixel RAM sits on the memory bus.
// ---------------------------------------------------------------------------
module tb_rgb_mem_arbiter;
    import rgb_mem_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

    logic clk;
    logic rst;

    rgb_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rgb_mem_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .MAX_VGA_STREAK (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          we;
        logic [1:0]    rgb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] expRdata;
        int            expLat;
        logic          expEn;
    } vec_t;

    localparam int NVEC = 14;

    vec_t        vecs [NVEC];
    logic [DW-1:0] plane [4][65536];
    logic [31:0] cpuExpQ [$];
    logic [31:0] pixExpQ [$];
    logic [31:0] monExp;
    int          total = 0;
    int          bad   = 0;

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel RAM: one plane per channel code, synchronous read.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                plane[bus.mem_sel][bus.mem_addr] <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= plane[bus.mem_sel][bus.mem_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every completion pulse pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cpu_ready) begin
                if (cpuExpQ.size() == 0) begin
                    checkOutput("cpuReadyUnexpected", 32'd1, 32'd0);
                end else begin
                    monExp = cpuExpQ.pop_front();
                    checkOutput("cpuRdata", 32'(bus.cpu_rdata), monExp);
                end
            end
            if (bus.vga_valid) begin
                if (pixExpQ.size() == 0) begin
                    checkOutput("vgaValidUnexpected", 32'd1, 32'd0);
                end else begin
                    monExp = pixExpQ.pop_front();
                    checkOutput("vgaPixel", 32'(bus.vga_pixel), monExp);
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'd0);
        checkOutput({tag, "_cpu_ready"}, 32'(bus.cpu_ready), 32'd0);
        checkOutput({tag, "_stall"},     32'(bus.stall),     32'd0);
        checkOutput({tag, "_vga_ack"},   32'(bus.vga_ack),   32'd0);
        checkOutput({tag, "_vga_pixel"}, 32'(bus.vga_pixel), 32'd0);
        checkOutput({tag, "_vga_valid"}, 32'(bus.vga_valid), 32'd0);
        checkOutput({tag, "_mem_en"},    32'(bus.mem_en),    32'd0);
        checkOutput({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        checkOutput({tag, "_mem_sel"},   32'(bus.mem_sel),   32'd0);
        checkOutput({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    endtask

    // One CPU transaction from an idle arbiter; checks latency, the memory
    // strobes of the access cycle, stall while waiting and after release.
    task automatic applyStimulus(input vec_t v, input int idx);
        int         cyc;
        logic       done;
        logic       enSeen;
        logic       weSeen;
        logic [1:0] selSeen;
        string      tag;
        tag     = $sformatf("vec%0d", idx);
        cyc     = 0;
        done    = 1'b0;
        enSeen  = 1'b0;
        weSeen  = 1'b0;
        selSeen = 2'b00;
        @(posedge clk);
        #1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = v.we;
        bus.cpu_rgb   = v.rgb;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        cpuExpQ.push_back(32'(v.expRdata));
        while (!done && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                enSeen  = bus.mem_en;
                weSeen  = bus.mem_we;
                selSeen = bus.mem_sel;
            end
            if (bus.cpu_ready) begin
                done = 1'b1;
            end else begin
                checkOutput({tag, "_stallWaiting"}, 32'(bus.stall), 32'd1);
            end
        end
        checkOutput({tag, "_readySeen"}, 32'(done), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(v.expLat));
        checkOutput({tag, "_memEn"}, 32'(enSeen), 32'(v.expEn));
        if (v.expEn) begin
            checkOutput({tag, "_memSel"}, 32'(selSeen), 32'(v.rgb));
            checkOutput({tag, "_memWe"}, 32'(weSeen), 32'(v.we));
        end
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_stallAfter"}, 32'(bus.stall), 32'd0);
        checkOutput({tag, "_readyAfter"}, 32'(bus.cpu_ready), 32'd0);
    endtask

    // One VGA fetch from an idle arbiter; the address is scrambled right
    // after the ack to show that G and B use the latched address.
    task automatic vgaFetch(input logic [AW-1:0] addr, input logic [31:0] expPix,
                            input string tag);
        int   waitCyc;
        int   n;
        logic got;
        logic seen;
        waitCyc = 0;
        got     = 1'b0;
        seen    = 1'b0;
        @(posedge clk);
        #1;
        bus.vga_req  = 1'b1;
        bus.vga_addr = addr;
        pixExpQ.push_back(expPix);
        while (!got && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
            if (bus.vga_ack) begin
                got = 1'b1;
            end
        end
        checkOutput({tag, "_ackSeen"}, 32'(got), 32'd1);
        checkOutput({tag, "_ackWait"}, 32'(waitCyc), 32'd2);
        @(posedge clk);
        #1;
        bus.vga_req  = 1'b0;
        bus.vga_addr = 16'hFFFF;
        n = 1;
        while (!seen && n < 12) begin
            @(negedge clk);
            if (bus.vga_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                n++;
            end
        end
        checkOutput({tag, "_validSeen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_ackToValid"}, 32'(n), 32'd4);
    endtask

    initial begin
        int   acks;
        int   cyc;
        int   validCount;
        logic done;
        logic got;

        vecs[0]  = '{1'b1, 2'b10, 16'h0010, 8'hA5, 8'h00, 1, 1'b1};
        vecs[1]  = '{1'b1, 2'b01, 16'h0020, 8'h3C, 8'h00, 1, 1'b1};
        vecs[2]  = '{1'b1, 2'b01, 16'h0100, 8'h11, 8'h00, 1, 1'b1};
        vecs[3]  = '{1'b1, 2'b10, 16'h0100, 8'h22, 8'h00, 1, 1'b1};
        vecs[4]  = '{1'b1, 2'b11, 16'h0100, 8'h33, 8'h00, 1, 1'b1};
        vecs[5]  = '{1'b1, 2'b01, 16'h0200, 8'h5A, 8'h00, 1, 1'b1};
        vecs[6]  = '{1'b1, 2'b10, 16'h0200, 8'hC3, 8'h00, 1, 1'b1};
        vecs[7]  = '{1'b1, 2'b11, 16'h0200, 8'h0F, 8'h00, 1, 1'b1};
        vecs[8]  = '{1'b1, 2'b00, 16'h0010, 8'hFF, 8'h00, 1, 1'b0};
        vecs[9]  = '{1'b0, 2'b01, 16'h0020, 8'h00, 8'h3C, 2, 1'b1};
        vecs[10] = '{1'b0, 2'b10, 16'h0010, 8'h00, 8'hA5, 2, 1'b1};
        vecs[11] = '{1'b0, 2'b00, 16'h0020, 8'h00, 8'h00, 1, 1'b0};
        vecs[12] = '{1'b0, 2'b11, 16'h0100, 8'h00, 8'h33, 2, 1'b1};
        vecs[13] = '{1'b0, 2'b10, 16'h0200, 8'h00, 8'hC3, 2, 1'b1};

        rst           = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_rgb   = 2'b00;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.vga_req   = 1'b0;
        bus.vga_addr  = '0;

        repeat (2) @(negedge clk);
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] CPU transaction table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] VGA fetch");
        vgaFetch(16'h0100, 32'h00112233, "fetch1");
        repeat (3) @(negedge clk);
        checkOutput("pixelHold", 32'(bus.vga_pixel), 32'h00112233);
        checkOutput("validPulseOnly", 32'(bus.vga_valid), 32'd0);

        $display("[TB] CPU starvation bound");
        @(posedge clk);
        #1;
        bus.vga_req  = 1'b1;
        bus.vga_addr = 16'h0200;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_rgb  = 2'b01;
        bus.cpu_addr = 16'h0020;
        cpuExpQ.push_back(32'h3C);
        repeat (4) pixExpQ.push_back(32'h005AC30F);
        acks = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.vga_ack) begin
                acks++;
            end
            if (bus.cpu_ready) begin
                done = 1'b1;
            end else begin
                checkOutput("stallStarve", 32'(bus.stall), 32'd1);
            end
        end
        checkOutput("starveReadySeen", 32'(done), 32'd1);
        checkOutput("vgaGrantsBeforeCpu", 32'(acks), 32'd4);
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        bus.vga_req = 1'b0;
        pixExpQ.push_back(32'h005AC30F);
        repeat (10) @(negedge clk);

        $display("[TB] reset during VGA_G");
        @(posedge clk);
        #1;
        bus.vga_req  = 1'b1;
        bus.vga_addr = 16'h0100;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.vga_ack) begin
                got = 1'b1;
            end
        end
        checkOutput("abortAckSeen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.vga_req = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("midReset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        validCount = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.vga_valid) begin
                validCount++;
            end
        end
        checkOutput("noValidAfterAbort", 32'(validCount), 32'd0);
        checkOutput("pixelAfterAbort", 32'(bus.vga_pixel), 32'd0);
        vgaFetch(16'h0100, 32'h00112233, "fetchAfterReset");

        repeat (4) @(negedge clk);
        checkOutput("cpuQueueDrained", 32'(cpuExpQ.size()), 32'd0);
        checkOutput("pixQueueDrained", 32'(pixExpQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
